td4x_core: RTL and testbench
============================

Name: td4x_core

Overview:
- Parametrised successor to the 4-bit TD4 CPU core: A/B registers, PC, output register and ALU, generalised to DATA_W data and ADDR_W address bits.
- Adds over the 4-bit core:
  - properly registered carry flag;
  - synchronous reset;
  - run/pause control;
  - HLT instruction;
  - output-valid strobe.
- Instruction memory is external and combinational-read. The core drives imem_addr and samples imem_data in the same cycle.

Parameters:
- DATA_W, 4: width of A, B, OUT, in_port and immediate field. Must be >= ADDR_W.
- ADDR_W, 4: PC width. Program space is 2^ADDR_W words.
- INSTR_W, 4+DATA_W: derived, not overridable. Format is {op[3:0], imm[DATA_W-1:0]}.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- run  in  1  1 = execute one instruction per cycle; 0 = hold all state
- imem_addr  out  ADDR_W  instruction fetch address (= PC)
- imem_data  in  INSTR_W  instruction at imem_addr, same cycle
- in_port  in  DATA_W  input port, sampled by IN instructions
- out_port  out  DATA_W  output register
- out_valid  out  1  one-cycle pulse in the cycle after an OUT executes
- halted  out  1  high in HALT state
- carry  out  1  current carry flag

Behaviour:
- Reset (rst=1 at posedge; overrides everything including a mid-instruction cycle):
  - A=0, B=0, PC=0, out_port=0, carry=0, out_valid=0, halted=0.
  - state=IDLE.
- States:
  - IDLE: run=1 -> RUN. No instruction executes in the transition cycle.
  - RUN: run=1 -> execute the instruction at PC this cycle. run=0 -> stay in RUN; no register, PC, carry or output update; out_valid=0.
  - HLT executed -> HALT.
  - HALT: absorbing; only rst exits. PC holds at the HLT address + 1. halted=1.
- Execute, one instruction per cycle:
  - alu = src + imm, DATA_W bits; cout = carry out of bit DATA_W-1.
  - Opcodes:
    - 0000 ADD A,imm: src=A, A<=alu.
    - 0001 MOV A,B: src=B, imm must be 0, A<=alu.
    - 0010 IN A: src=in_port, A<=alu.
    - 0011 MOV A,imm: src=0, A<=alu.
    - 0100 MOV B,A: src=A, B<=alu.
    - 0101 ADD B,imm: src=B, B<=alu.
    - 0110 IN B: src=in_port, B<=alu.
    - 0111 MOV B,imm: src=0, B<=alu.
    - 1001 OUT B: src=B, out_port<=alu.
    - 1011 OUT imm: src=0, out_port<=alu.
    - 1111 JMP imm: PC<=imm[ADDR_W-1:0].
    - 1110 JNC imm: if carry==0, PC<=imm[ADDR_W-1:0].
    - 1000 HLT.
    - All other opcodes: NOP.
  - Carry:
    - Data and OUT instructions: carry<=cout.
    - JMP/JNC: carry<=0.
    - NOP/HLT: carry unchanged.
    - JNC tests the carry value from before this instruction's update.
  - PC:
    - Non-taken jumps and all other instructions: PC<=PC+1, wrapping modulo 2^ADDR_W.
    - A jump to its own address is legal and loops.
  - out_valid=1 exactly in the cycle after an OUT, else 0. Back-to-back OUTs give consecutive pulses.
  - Immediate width: the imm upper bits above ADDR_W are ignored for jumps.

Optional Feature:
- Macro TD4X_JC_EN.
- Defined: opcode 1101 = JC imm. Jump if carry==1, carry<=0.
- Undefined: 1101 is a NOP.

Decomposition:
- Package td4x_pkg:
  - opcode localparams OP_ADD_A .. OP_HLT, OP_JC;
  - state enum IDLE/RUN/HALT;
  - no parameter-dependent types.
- One sub-module, td4x_alu: combinational DATA_W adder, ports a, b, sum, cout. Instantiated once.

Test Plan:
- DATA_W=4: rst, then run=1. Program MOV A,3; ADD A,14; JNC 0; OUT imm 5; HLT.
  - ADD gives A=1, carry=1.
  - JNC not taken; carry then cleared.
  - out_port=5; out_valid pulses once.
  - halted=1 with PC=5.
- Program JMP 15 then 0xF: ADD B,1 (B=15 preloaded via MOV B,15).
  - B wraps to 0, carry=1.
  - PC wraps 15->0.
- run toggled 1,0,0,1 during a MOV B,A; OUT B loop.
  - No state change and out_valid=0 while run=0.
  - Execution resumes at the same PC.
- rst asserted in the same cycle an OUT executes.
  - Next cycle out_port=0, out_valid=0, state IDLE.
  - No execution until run=1.
- DATA_W=8, ADDR_W=6: JMP 0xC5 -> PC=0x05.
  - IN A with in_port=0xFF, then ADD A,1 -> A=0x00, carry=1.
- TD4X_JC_EN on vs off: carry=1, opcode 1101 imm 9.
  - With the macro: PC=9.
  - Without: PC+1, carry unchanged.

Source files
------------

// File: rtl/td4x_pkg.sv
// Shared opcodes and FSM state encoding for the td4x core.
package td4x_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_HLT    = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JC     = 4'b1101;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/td4x_alu.sv
// Combinational DATA_W adder with carry out of the top bit.
module td4x_alu #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sum  = full[DATA_W-1:0];
  assign cout = full[DATA_W];

endmodule

// File: rtl/td4x_core.sv
// Parametrised TD4-style CPU core with run/pause, HLT and output strobe.
// Optional JC instruction (opcode 1101) enabled by defining TD4X_JC_EN.
module td4x_core
  import td4x_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  localparam int INSTR_W = 4 + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic [DATA_W-1:0]  in_port,
  output logic [DATA_W-1:0]  out_port,
  output logic               out_valid,
  output logic               halted,
  output logic               carry
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, out_q, out_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                carry_q, carry_d, out_valid_q, out_valid_d, halted_q, halted_d;

  logic [3:0]          op;
  logic [DATA_W-1:0]   imm, src, alu_sum;
  logic                alu_cout;
  logic [ADDR_W-1:0]   pc_inc, jmp_tgt;

  assign op      = imem_data[INSTR_W-1 -: 4];
  assign imm     = imem_data[DATA_W-1:0];
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign jmp_tgt = imm[ADDR_W-1:0];

  always_comb begin
    src = '0;
    case (op)
      OP_ADD_A, OP_MOV_BA:           src = a_q;
      OP_MOV_AB, OP_ADD_B, OP_OUT_B: src = b_q;
      OP_IN_A, OP_IN_B:              src = in_port;
      default:                       src = '0;
    endcase
  end

  td4x_alu #(.DATA_W(DATA_W)) u_alu (
    .a    (src),
    .b    (imm),
    .sum  (alu_sum),
    .cout (alu_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    out_d       = out_q;
    pc_d        = pc_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: if (run) state_d = RUN;
      RUN: if (run) begin
        pc_d = pc_inc;
        case (op)
          OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI: begin
            a_d     = alu_sum;
            carry_d = alu_cout;
          end
          OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI: begin
            b_d     = alu_sum;
            carry_d = alu_cout;
          end
          OP_OUT_B, OP_OUT_I: begin
            out_d       = alu_sum;
            carry_d     = alu_cout;
            out_valid_d = 1'b1;
          end
          OP_JMP: begin
            pc_d    = jmp_tgt;
            carry_d = 1'b0;
          end
          // JNC looks at the flag as it stood before this instruction
          OP_JNC: begin
            if (!carry_q) pc_d = jmp_tgt;
            carry_d = 1'b0;
          end
`ifdef TD4X_JC_EN
          OP_JC: begin
            if (carry_q) pc_d = jmp_tgt;
            carry_d = 1'b0;
          end
`endif
          OP_HLT: state_d = HALT;
          default: ;
        endcase
      end
      default: ;
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      pc_q        <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      pc_q        <= pc_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_port  = out_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_td4x_core.sv
// Table-driven bench for td4x_core at 4/4 and 8/6 widths, with an output scoreboard.
module tb_td4x_core;

  typedef struct {
    bit          rst;
    bit          run;
    logic [11:0] instr;
    logic [7:0]  inp;
    logic [5:0]  pc;
    bit          c;
    bit          ov;
    logic [7:0]  out;
    bit          h;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4 = 1'b1, run4 = 1'b0;
  logic [7:0] imem4 = '0;
  logic [3:0] in4 = '0, pc4, out4;
  logic       ov4, h4, c4;

  logic        rst8 = 1'b1, run8 = 1'b0;
  logic [11:0] imem8 = '0;
  logic [7:0]  in8 = '0, out8;
  logic [5:0]  pc8;
  logic        ov8, h8, c8;

  td4x_core #(.DATA_W(4), .ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst4), .run(run4), .imem_addr(pc4), .imem_data(imem4),
    .in_port(in4), .out_port(out4), .out_valid(ov4), .halted(h4), .carry(c4)
  );

  td4x_core #(.DATA_W(8), .ADDR_W(6)) dut8 (
    .clk(clk), .rst(rst8), .run(run8), .imem_addr(pc8), .imem_data(imem8),
    .in_port(in8), .out_port(out8), .out_valid(ov8), .halted(h8), .carry(c8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb4[$];
  logic [7:0] sb8[$];
  vec_t t4[$];
  vec_t t8[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, bit run, logic [11:0] instr, logic [7:0] inp,
                              logic [5:0] pc, bit c, bit ov, logic [7:0] out, bit h);
    vec_t v;
    v.rst = rst; v.run = run; v.instr = instr; v.inp = inp;
    v.pc = pc; v.c = c; v.ov = ov; v.out = out; v.h = h;
    return v;
  endfunction

  task automatic apply(input vec_t v, input bit wide, input int idx);
    logic [5:0] pc_a;
    logic [7:0] out_a, sb_exp;
    logic       c_a, ov_a, h_a;
    string      tag;
    if (!wide) begin
      rst4 = v.rst; run4 = v.run; imem4 = v.instr[7:0]; in4 = v.inp[3:0];
      if (v.ov) sb4.push_back(v.out);
    end else begin
      rst8 = v.rst; run8 = v.run; imem8 = v.instr; in8 = v.inp;
      if (v.ov) sb8.push_back(v.out);
    end
    @(posedge clk);
    #1;
    if (!wide) begin
      pc_a = {2'b00, pc4}; out_a = {4'h0, out4}; c_a = c4; ov_a = ov4; h_a = h4;
    end else begin
      pc_a = pc8; out_a = out8; c_a = c8; ov_a = ov8; h_a = h8;
    end
    tag = $sformatf("%s[%0d]", wide ? "w8" : "w4", idx);
    chk({tag, " pc"},        32'(pc_a),  32'(v.pc));
    chk({tag, " carry"},     32'(c_a),   32'(v.c));
    chk({tag, " out_valid"}, 32'(ov_a),  32'(v.ov));
    chk({tag, " out_port"},  32'(out_a), 32'(v.out));
    chk({tag, " halted"},    32'(h_a),   32'(v.h));
    if (ov_a) begin
      if ((wide ? sb8.size() : sb4.size()) == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s sb_unexpected: got out_valid=1 expected no pending output", tag);
      end else begin
        sb_exp = wide ? sb8.pop_front() : sb4.pop_front();
        chk({tag, " sb_out"}, 32'(out_a), 32'(sb_exp));
      end
    end
  endtask

  initial begin
    // rst run instr in | pc c ov out h
    t4.push_back(mk(1, 0, 12'h000, 8'h0, 6'd0,  0, 0, 8'h0, 0));
    t4.push_back(mk(1, 1, 12'h0B7, 8'h0, 6'd0,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h0B7, 8'h0, 6'd0,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h07F, 8'h0, 6'd1,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h0FF, 8'h0, 6'd15, 0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h051, 8'h0, 6'd0,  1, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h090, 8'h0, 6'd1,  0, 1, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h0E7, 8'h0, 6'd7,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h0F7, 8'h0, 6'd7,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h039, 8'h0, 6'd8,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h040, 8'h0, 6'd9,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h058, 8'h0, 6'd10, 1, 0, 8'h0, 0));
    t4.push_back(mk(0, 0, 12'h090, 8'h0, 6'd10, 1, 0, 8'h0, 0));
    t4.push_back(mk(0, 0, 12'h090, 8'h0, 6'd10, 1, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h090, 8'h0, 6'd11, 0, 1, 8'h1, 0));
    t4.push_back(mk(0, 0, 12'h040, 8'h0, 6'd11, 0, 0, 8'h1, 0));
    t4.push_back(mk(0, 0, 12'h040, 8'h0, 6'd11, 0, 0, 8'h1, 0));
    t4.push_back(mk(0, 1, 12'h040, 8'h0, 6'd12, 0, 0, 8'h1, 0));
    t4.push_back(mk(0, 1, 12'h090, 8'h0, 6'd13, 0, 1, 8'h9, 0));
    t4.push_back(mk(0, 1, 12'h090, 8'h0, 6'd14, 0, 1, 8'h9, 0));
    t4.push_back(mk(1, 1, 12'h0B3, 8'h0, 6'd0,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 0, 12'h0B3, 8'h0, 6'd0,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h0B3, 8'h0, 6'd0,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h0B3, 8'h0, 6'd1,  0, 1, 8'h3, 0));
    t4.push_back(mk(0, 1, 12'h020, 8'hF, 6'd2,  0, 0, 8'h3, 0));
    t4.push_back(mk(0, 1, 12'h001, 8'h0, 6'd3,  1, 0, 8'h3, 0));
`ifdef TD4X_JC_EN
    t4.push_back(mk(0, 1, 12'h0D9, 8'h0, 6'd9,  0, 0, 8'h3, 0));
    t4.push_back(mk(0, 1, 12'h0A5, 8'h0, 6'd10, 0, 0, 8'h3, 0));
`else
    t4.push_back(mk(0, 1, 12'h0D9, 8'h0, 6'd4,  1, 0, 8'h3, 0));
    t4.push_back(mk(0, 1, 12'h0A5, 8'h0, 6'd5,  1, 0, 8'h3, 0));
`endif
    t4.push_back(mk(1, 0, 12'h000, 8'h0, 6'd0,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h033, 8'h0, 6'd0,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h033, 8'h0, 6'd1,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h00E, 8'h0, 6'd2,  1, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h0E0, 8'h0, 6'd3,  0, 0, 8'h0, 0));
    t4.push_back(mk(0, 1, 12'h0B5, 8'h0, 6'd4,  0, 1, 8'h5, 0));
    t4.push_back(mk(0, 1, 12'h080, 8'h0, 6'd5,  0, 0, 8'h5, 1));
    t4.push_back(mk(0, 1, 12'h0B9, 8'h0, 6'd5,  0, 0, 8'h5, 1));
    t4.push_back(mk(0, 0, 12'h0F0, 8'h0, 6'd5,  0, 0, 8'h5, 1));
    t4.push_back(mk(0, 1, 12'h033, 8'h0, 6'd5,  0, 0, 8'h5, 1));

    t8.push_back(mk(1, 0, 12'h000, 8'h00, 6'd0,  0, 0, 8'h00, 0));
    t8.push_back(mk(0, 1, 12'hFC5, 8'h00, 6'd0,  0, 0, 8'h00, 0));
    t8.push_back(mk(0, 1, 12'hFC5, 8'h00, 6'd5,  0, 0, 8'h00, 0));
    t8.push_back(mk(0, 1, 12'h200, 8'hFF, 6'd6,  0, 0, 8'h00, 0));
    t8.push_back(mk(0, 1, 12'h001, 8'h00, 6'd7,  1, 0, 8'h00, 0));
    t8.push_back(mk(0, 1, 12'h02A, 8'h00, 6'd8,  0, 0, 8'h00, 0));
    t8.push_back(mk(0, 1, 12'h400, 8'h00, 6'd9,  0, 0, 8'h00, 0));
    t8.push_back(mk(0, 1, 12'h900, 8'h00, 6'd10, 0, 1, 8'h2A, 0));
    t8.push_back(mk(0, 1, 12'hFC0, 8'h00, 6'd0,  0, 0, 8'h2A, 0));

    @(posedge clk);
    #1;
    foreach (t4[i]) apply(t4[i], 1'b0, i);
    rst4 = 1'b1; run4 = 1'b0;
    foreach (t8[i]) apply(t8[i], 1'b1, i);

    chk("sb4_drained", 32'(sb4.size()), 32'd0);
    chk("sb8_drained", 32'(sb8.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
